// File: rtl/gpioemu_prime_mc.sv
// gpioemu_prime_mc: bus-mapped prime engine for the gpioemu peripheral family.
//
// The host writes argument A. A trial-division FSM then computes one of two
// results, selected by the mode bit in CTRL:
//   mode 0: the A-th prime
//   mode 1: the count of primes <= A
// The block also has a status register, restart-on-write, an argument range
// check and a snapshot latch for the GPIO inputs.
//
// Ports:
//   clk            system clock; all logic runs on the rising edge
//   n_reset        asynchronous active-low reset
//   saddress       bus address
//   srd / swr      read / write strobes (asynchronous level pulses)
//   sdata_in       write data
//   sdata_out      registered read data, held until the next read
//   gpio_in        external inputs
//   gpio_latch     capture strobe for gpio_in (asynchronous pulse)
//   gpio_out       RESULT, zero-extended
//   gpio_in_s_insp latched gpio_in snapshot
module gpioemu_prime_mc #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RES_W     = 16,
  parameter int unsigned MAX_A     = 1000,
  parameter logic [15:0] ADDR_A    = 16'h224,
  parameter logic [15:0] ADDR_CTRL = 16'h228,
  parameter logic [15:0] ADDR_RES  = 16'h234,
  parameter logic [15:0] ADDR_STAT = 16'h23C
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [15:0]       saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [DATA_W-1:0] sdata_in,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [DATA_W-1:0] gpio_in,
  input  logic              gpio_latch,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] gpio_in_s_insp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  // Strobe synchronisers: bits [1:0] form the 2-flop synchroniser and bit [2]
  // holds the previous synchronised value for rising-edge detection.
  logic [2:0] srd_sync_q, swr_sync_q, lat_sync_q;
  logic       rd_edge, wr_edge, lat_edge;

  state_t           state_q, state_d;
  logic [RES_W-1:0] a_q, a_d;
  logic             mode_q, mode_d;
  logic             run_mode_q, run_mode_d;
  logic [RES_W-1:0] cand_q, cand_d;
  logic [RES_W-1:0] d_q, d_d;
  logic [RES_W-1:0] found_q, found_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy;

  logic [2*RES_W-1:0] d_sq;
  logic [RES_W-1:0]   rem;
  logic               a_invalid;
  logic [DATA_W-1:0]  rd_data;

  assign rd_edge  = srd_sync_q[1] & ~srd_sync_q[2];
  assign wr_edge  = swr_sync_q[1] & ~swr_sync_q[2];
  assign lat_edge = lat_sync_q[1] & ~lat_sync_q[2];

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign d_sq      = (2*RES_W)'(d_q) * (2*RES_W)'(d_q);
  assign rem       = cand_q % d_q;
  assign a_invalid = (sdata_in == '0) || (sdata_in > DATA_W'(MAX_A));
  assign gpio_out  = DATA_W'(result_q);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    mode_d     = mode_q;
    run_mode_d = run_mode_q;
    cand_d     = cand_q;
    d_d        = d_q;
    found_d    = found_q;
    result_d   = result_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_INIT: begin
        cand_d     = RES_W'(2);
        d_d        = RES_W'(2);
        found_d    = '0;
        run_mode_d = mode_q;
        if (mode_q && (a_q == RES_W'(1))) begin
          result_d = '0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (d_sq > (2*RES_W)'(cand_q)) begin
          found_d = found_q + RES_W'(1);
          state_d = S_CHECK;
        end else if (rem == '0) begin
          state_d = S_NEXT;
        end else begin
          d_d = d_q + RES_W'(1);
        end
      end
      S_CHECK: begin
        if (!run_mode_q && (found_q == a_q)) begin
          result_d = cand_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (run_mode_q && (cand_q == a_q)) begin
          result_d = found_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cand_d  = cand_q + RES_W'(1);
          d_d     = RES_W'(2);
          state_d = S_TEST;
        end
      end
      default: ;
    endcase

    // A write to A is applied after the FSM step so that it overrides a
    // simultaneous DONE transition (done stays 0, FSM restarts).
    if (wr_edge && (saddress == ADDR_A)) begin
      a_d    = sdata_in[RES_W-1:0];
      done_d = 1'b0;
      if (a_invalid) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        err_d   = 1'b0;
        state_d = S_INIT;
      end
    end
    if (wr_edge && (saddress == ADDR_CTRL)) begin
      mode_d = sdata_in[0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (saddress)
      ADDR_RES:  rd_data = DATA_W'(result_q);
      ADDR_STAT: rd_data = DATA_W'({mode_q, err_q, done_q, busy});
      ADDR_A:    rd_data = DATA_W'(a_q);
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_sync_q     <= '0;
      swr_sync_q     <= '0;
      lat_sync_q     <= '0;
      state_q        <= S_IDLE;
      a_q            <= '0;
      mode_q         <= 1'b0;
      run_mode_q     <= 1'b0;
      cand_q         <= '0;
      d_q            <= '0;
      found_q        <= '0;
      result_q       <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      sdata_out      <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      srd_sync_q <= {srd_sync_q[1:0], srd};
      swr_sync_q <= {swr_sync_q[1:0], swr};
      lat_sync_q <= {lat_sync_q[1:0], gpio_latch};
      state_q    <= state_d;
      a_q        <= a_d;
      mode_q     <= mode_d;
      run_mode_q <= run_mode_d;
      cand_q     <= cand_d;
      d_q        <= d_d;
      found_q    <= found_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (rd_edge) begin
        sdata_out <= rd_data;
      end
      if (lat_edge) begin
        gpio_in_s_insp <= gpio_in;
      end
    end
  end

endmodule
